// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: sole reader of the 8-entry byte FIFO. Each byte is fetched
// with a single rd_en pulse and shifted out as one UART 8N1 frame
// (start bit, 8 data bits LSB first, stop bit).
//
// Handshake: fifo_rd_en is a one-cycle strobe, raised only in IDLE when
// tx_enable is high and fifo_empty is low. The FIFO returns the byte on
// fifo_data in the following cycle (FETCH), where it is captured. There is
// exactly one read per frame.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_reg_next;
  logic             tx_next;
  logic             busy_next;
  logic [15:0]      bytes_sent_next;
  logic             baud_done;

  // Last cycle of the current bit period.
  assign baud_done = (baud_cnt == CNT_LAST);

  // State and datapath registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      bytes_sent <= '0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_reg_next;
      tx         <= tx_next;
      busy       <= busy_next;
      bytes_sent <= bytes_sent_next;
    end
  end

  // Next-state, read strobe and next register values.
  always_comb begin
    state_next      = state;
    baud_cnt_next   = baud_cnt;
    bit_idx_next    = bit_idx;
    shift_reg_next  = shift_reg;
    tx_next         = tx;
    bytes_sent_next = bytes_sent;
    fifo_rd_en      = 1'b0;

    case (state)
      IDLE: begin
        // rst_n term keeps the strobe low during reset even though
        // the other inputs may request a read.
        fifo_rd_en = tx_enable & ~fifo_empty & rst_n;
        if (fifo_rd_en) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        // Read data is valid now; the start bit begins at this edge.
        shift_reg_next = fifo_data;
        tx_next        = 1'b0;
        baud_cnt_next  = '0;
        state_next     = START;
      end

      START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          tx_next       = shift_reg[0];
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_cnt_next   = '0;
          bytes_sent_next = bytes_sent + 16'd1;
          state_next      = IDLE;
        end else begin
          baud_cnt_next = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with CLKS_PER_BIT = 4.
// A small FIFO model answers rd_en with registered data one cycle later.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam time PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;

  int total = 0;
  int bad = 0;

  // FIFO model state
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int  push_n = 0;
  int  pop_n = 0;
  int  rd_cnt = 0;
  time last_rd_time = 0;
  int  exp_sent = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .bytes_sent (bytes_sent)
  );

  // clock / reset block
  always #(PERIOD / 2) clk = ~clk;

  assign fifo_empty = (push_n == pop_n);

  // FIFO read port model: registered data, one entry per strobe
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      last_rd_time = $time;
      if (fifo_q.size() > 0) begin
        fifo_data <= fifo_q.pop_front();
        pop_n     <= pop_n + 1;
      end
    end
  end

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    push_n++;
  endtask

  // Waits (bounded) for a start bit, then samples each bit period.
  // Returns at the negedge following the last stop-bit cycle.
  task automatic get_frame(output logic [9:0] bits, output bit stable,
                           output bit ok, output time t_start);
    bits = '0;
    stable = 1'b1;
    ok = 1'b0;
    t_start = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    t_start = $time;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k % CPB == 0) bits[k / CPB] = tx;
      else if (tx !== bits[k / CPB]) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic test_reset();
    logic [9:0] bits;
    bit stable, ok;
    time t0;
    logic [7:0] eb;
    rst_n = 1'b0;
    tx_enable = 1'b1;
    push(8'h11);
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
    total++; if (bytes_sent !== 16'd0) begin bad++; $display("FAIL reset_bytes got=%0d want=0", bytes_sent); end
    rst_n = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL reset_first_rd got=%b want=1", fifo_rd_en); end
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%b want=1", busy); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL fetch_rd_en got=%b want=0", fifo_rd_en); end
    get_frame(bits, stable, ok, t0);
    eb = exp_q.pop_front();
    exp_sent++;
    total++; if (!ok) begin bad++; $display("FAIL reset_frame_start got=timeout want=start bit"); end
    total++; if (bits !== frame_of(eb)) begin bad++; $display("FAIL reset_frame_bits got=%b want=%b", bits, frame_of(eb)); end
    total++; if (t0 - last_rd_time != 15) begin bad++; $display("FAIL rd_to_tx_latency got=%0t want=15", t0 - last_rd_time); end
  endtask

  task automatic test_single();
    logic [9:0] bits;
    bit stable, ok;
    time t0;
    logic [7:0] eb;
    int n0;
    n0 = rd_cnt;
    push(8'hA5);
    get_frame(bits, stable, ok, t0);
    eb = exp_q.pop_front();
    exp_sent++;
    total++; if (!ok) begin bad++; $display("FAIL single_start got=timeout want=start bit"); end
    total++; if (bits !== 10'b1_1010_0101_0) begin bad++; $display("FAIL single_bits got=%b want=%b", bits, 10'b1_1010_0101_0); end
    total++; if (bits !== frame_of(eb)) begin bad++; $display("FAIL single_scoreboard got=%b want=%b", bits, frame_of(eb)); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL single_bit_hold got=%b want=1", stable); end
    total++; if (rd_cnt != n0 + 1) begin bad++; $display("FAIL single_reads got=%0d want=%0d", rd_cnt - n0, 1); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    total++; if (bytes_sent !== 16'(exp_sent)) begin bad++; $display("FAIL single_bytes got=%0d want=%0d", bytes_sent, exp_sent); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    bit stable, ok;
    time t0, t_prev;
    logic [7:0] eb;
    int n0;
    n0 = rd_cnt;
    t_prev = 0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    for (int f = 0; f < 3; f++) begin
      get_frame(bits, stable, ok, t0);
      eb = exp_q.pop_front();
      exp_sent++;
      total++; if (!ok || bits !== frame_of(eb) || !stable) begin bad++; $display("FAIL b2b_frame%0d got=%b ok=%b stable=%b want=%b", f, bits, ok, stable, frame_of(eb)); end
      if (f > 0) begin
        total++; if (t0 - t_prev != (10 * CPB + 2) * PERIOD) begin bad++; $display("FAIL b2b_spacing%0d got=%0t want=%0t", f, t0 - t_prev, (10 * CPB + 2) * PERIOD); end
      end
      t_prev = t0;
    end
    repeat (20) @(negedge clk);
    total++; if (rd_cnt != n0 + 3) begin bad++; $display("FAIL b2b_reads got=%0d want=3", rd_cnt - n0); end
    total++; if (bytes_sent !== 16'(exp_sent)) begin bad++; $display("FAIL b2b_bytes got=%0d want=%0d", bytes_sent, exp_sent); end
    total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", fifo_empty); end
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
  endtask

  task automatic test_enable();
    logic [9:0] bits;
    bit stable, ok;
    time t0;
    logic [7:0] eb;
    int n0;
    tx_enable = 1'b0;
    n0 = rd_cnt;
    push(8'h5A);
    push(8'hC3);
    repeat (20) @(negedge clk);
    total++; if (rd_cnt != n0) begin bad++; $display("FAIL en_off_reads got=%0d want=0", rd_cnt - n0); end
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL en_off_idle got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    tx_enable = 1'b1;
    fork
      get_frame(bits, stable, ok, t0);
      begin
        repeat (8) @(negedge clk);
        tx_enable = 1'b0;
      end
    join
    eb = exp_q.pop_front();
    exp_sent++;
    total++; if (!ok || bits !== frame_of(eb) || !stable) begin bad++; $display("FAIL en_drop_frame got=%b ok=%b stable=%b want=%b", bits, ok, stable, frame_of(eb)); end
    repeat (30) @(negedge clk);
    total++; if (rd_cnt != n0 + 1) begin bad++; $display("FAIL en_drop_reads got=%0d want=1", rd_cnt - n0); end
    total++; if (bytes_sent !== 16'(exp_sent) || busy !== 1'b0) begin bad++; $display("FAIL en_drop_done got bytes=%0d busy=%b want bytes=%0d busy=0", bytes_sent, busy, exp_sent); end
    tx_enable = 1'b1;
    get_frame(bits, stable, ok, t0);
    eb = exp_q.pop_front();
    exp_sent++;
    total++; if (!ok || bits !== frame_of(eb) || !stable) begin bad++; $display("FAIL en_resume_frame got=%b ok=%b stable=%b want=%b", bits, ok, stable, frame_of(eb)); end
    total++; if (rd_cnt != n0 + 2) begin bad++; $display("FAIL en_resume_reads got=%0d want=2", rd_cnt - n0); end
  endtask

  task automatic test_mid_reset();
    logic [9:0] bits;
    bit stable, ok;
    time t0;
    logic [7:0] eb;
    bit seen;
    push(8'h96);
    push(8'h3C);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_start got=timeout want=start bit"); end
    // start bit + bits 0..2, then one cycle into bit 3 (which is 0 for 0x96)
    repeat (4 * CPB + 1) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midrst_bit3 got=%b want=0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midrst_async got tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    total++; if (bytes_sent !== 16'd0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_clear got bytes=%0d rd_en=%b want bytes=0 rd_en=0", bytes_sent, fifo_rd_en); end
    eb = exp_q.pop_front();
    exp_sent = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    get_frame(bits, stable, ok, t0);
    eb = exp_q.pop_front();
    exp_sent++;
    total++; if (!ok || bits !== frame_of(eb) || !stable) begin bad++; $display("FAIL midrst_next_frame got=%b ok=%b stable=%b want=%b", bits, ok, stable, frame_of(eb)); end
    total++; if (bytes_sent !== 16'(exp_sent)) begin bad++; $display("FAIL midrst_bytes got=%0d want=%0d", bytes_sent, exp_sent); end
  endtask

  task automatic test_wrap();
    logic [9:0] bits;
    bit stable, ok;
    time t0;
    logic [7:0] eb;
    force dut.bytes_sent = 16'hFFFF;
    @(negedge clk);
    release dut.bytes_sent;
    push(8'h81);
    get_frame(bits, stable, ok, t0);
    eb = exp_q.pop_front();
    total++; if (!ok || bits !== frame_of(eb) || !stable) begin bad++; $display("FAIL wrap_frame got=%b ok=%b stable=%b want=%b", bits, ok, stable, frame_of(eb)); end
    total++; if (bytes_sent !== 16'h0000) begin bad++; $display("FAIL wrap_bytes got=%h want=0000", bytes_sent); end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_enable = 1'b0;
    fifo_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_enable();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
